// File: rtl/sys_arr.sv
// sys_arr: 5x5 output-stationary-free systolic multiply-accumulate grid.
//
// Every processing element PE(i,j) registers three values each rising edge:
//   a_out <= a_in             (a flows right along row i)
//   b_out <= b_in             (b flows down column j)
//   c_out <= c_in + a_in*b_in (c flows diagonally down-right)
// All arithmetic wraps modulo 2^(n+1).
//
// Ports:
//   a00..a40  row inputs, row i enters at the left of grid row i
//   b00..b04  column inputs, column j enters at the top of grid column j
//   c00,c01,c02,c10,c20  partial-sum heads of the five computing diagonals
//   a05..a45  row data leaving the right edge (5 edges after entry)
//   b50..b54  column data leaving the bottom edge (5 edges after entry)
//   c53,c54,c55,c35,c45  diagonal results (tails of c20,c10,c00,c02,c01)
//   clock     rising-edge clock for all state
//   reset_n   active-low asynchronous reset, clears every PE register
module sys_arr #(
  parameter int n = 31
) (
  input  logic [n:0] a00,
  input  logic [n:0] a10,
  input  logic [n:0] a20,
  input  logic [n:0] a30,
  input  logic [n:0] a40,
  input  logic [n:0] b00,
  input  logic [n:0] b01,
  input  logic [n:0] b02,
  input  logic [n:0] b03,
  input  logic [n:0] b04,
  input  logic [n:0] c00,
  input  logic [n:0] c01,
  input  logic [n:0] c02,
  input  logic [n:0] c10,
  input  logic [n:0] c20,
  output logic [n:0] a05,
  output logic [n:0] a15,
  output logic [n:0] a25,
  output logic [n:0] a35,
  output logic [n:0] a45,
  output logic [n:0] b50,
  output logic [n:0] b51,
  output logic [n:0] b52,
  output logic [n:0] b53,
  output logic [n:0] b54,
  output logic [n:0] c53,
  output logic [n:0] c54,
  output logic [n:0] c55,
  output logic [n:0] c35,
  output logic [n:0] c45,
  input  logic       clock,
  input  logic       reset_n
);

  localparam int Dim = 5;

  // PE state
  logic [n:0] a_q [Dim][Dim];
  logic [n:0] b_q [Dim][Dim];
  logic [n:0] c_q [Dim][Dim];
  logic [n:0] a_d [Dim][Dim];
  logic [n:0] b_d [Dim][Dim];
  logic [n:0] c_d [Dim][Dim];

  // Source networks: a_src[i][j] / b_src[i][j] / c_src[i][j] is the input seen by PE(i,j).
  // The extra row/column lets every PE read its neighbour without edge special-casing.
  logic [n:0] a_src [Dim][Dim+1];
  logic [n:0] b_src [Dim+1][Dim];
  logic [n:0] c_src [Dim+1][Dim+1];

  always_comb begin
    for (int i = 0; i < Dim; i++) begin
      for (int j = 0; j <= Dim; j++) begin
        a_src[i][j] = '0;
      end
    end
    for (int i = 0; i <= Dim; i++) begin
      for (int j = 0; j < Dim; j++) begin
        b_src[i][j] = '0;
      end
    end
    for (int i = 0; i <= Dim; i++) begin
      for (int j = 0; j <= Dim; j++) begin
        c_src[i][j] = '0;
      end
    end

    // Left edge feeds rows, top edge feeds columns.
    a_src[0][0] = a00;
    a_src[1][0] = a10;
    a_src[2][0] = a20;
    a_src[3][0] = a30;
    a_src[4][0] = a40;
    b_src[0][0] = b00;
    b_src[0][1] = b01;
    b_src[0][2] = b02;
    b_src[0][3] = b03;
    b_src[0][4] = b04;

    // Diagonal heads; PE(0,3), PE(0,4), PE(3,0), PE(4,0) keep their 0 default.
    c_src[0][0] = c00;
    c_src[0][1] = c01;
    c_src[0][2] = c02;
    c_src[1][0] = c10;
    c_src[2][0] = c20;

    for (int i = 0; i < Dim; i++) begin
      for (int j = 0; j < Dim; j++) begin
        a_src[i][j+1]   = a_q[i][j];
        b_src[i+1][j]   = b_q[i][j];
        c_src[i+1][j+1] = c_q[i][j];
      end
    end
  end

  // Next-state for every PE; product and sum are sized to n+1 bits, so they wrap.
  always_comb begin
    for (int i = 0; i < Dim; i++) begin
      for (int j = 0; j < Dim; j++) begin
        a_d[i][j] = a_src[i][j];
        b_d[i][j] = b_src[i][j];
        c_d[i][j] = c_src[i][j] + a_src[i][j] * b_src[i][j];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Dim; i++) begin
        for (int j = 0; j < Dim; j++) begin
          a_q[i][j] <= '0;
          b_q[i][j] <= '0;
          c_q[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < Dim; i++) begin
        for (int j = 0; j < Dim; j++) begin
          a_q[i][j] <= a_d[i][j];
          b_q[i][j] <= b_d[i][j];
          c_q[i][j] <= c_d[i][j];
        end
      end
    end
  end

  // Right edge
  assign a05 = a_q[0][4];
  assign a15 = a_q[1][4];
  assign a25 = a_q[2][4];
  assign a35 = a_q[3][4];
  assign a45 = a_q[4][4];

  // Bottom edge
  assign b50 = b_q[4][0];
  assign b51 = b_q[4][1];
  assign b52 = b_q[4][2];
  assign b53 = b_q[4][3];
  assign b54 = b_q[4][4];

  // Diagonal tails
  assign c55 = c_q[4][4];
  assign c45 = c_q[3][4];
  assign c35 = c_q[2][4];
  assign c54 = c_q[4][3];
  assign c53 = c_q[4][2];

endmodule

// File: tb/tb_sys_arr.sv
// Bench for sys_arr: directed vectors with hand-computed results. Stimulus pushes
// (edge, port, value) expectations into a queue; a monitor pops and compares them
// 1 time unit after each rising edge.
module tb_sys_arr;

  logic        clock;
  logic        reset_n;
  logic [31:0] a_in  [5];
  logic [31:0] b_in  [5];
  logic [31:0] c_in  [5];   // c00, c01, c02, c10, c20
  logic [31:0] a_out [5];   // a05 .. a45
  logic [31:0] b_out [5];   // b50 .. b54
  logic [31:0] c_out [5];   // c53, c54, c55, c35, c45

  // Output port ids
  localparam int A05 = 0;
  localparam int A15 = 1;
  localparam int B50 = 5;
  localparam int B53 = 8;
  localparam int C53 = 10;
  localparam int C54 = 11;
  localparam int C55 = 12;
  localparam int C35 = 13;
  localparam int C45 = 14;

  string names [15] = '{"a05", "a15", "a25", "a35", "a45",
                        "b50", "b51", "b52", "b53", "b54",
                        "c53", "c54", "c55", "c35", "c45"};

  typedef struct {
    int          cyc;
    int          port;
    logic [31:0] exp;
  } exp_t;

  exp_t sb [$];
  int   edge_cnt;
  int   errors;
  int   checks;

  // Matrices for the multiply scenarios, row-major
  logic [31:0] ma [9];
  logic [31:0] mb [9];
  logic [31:0] mc [9];

  sys_arr #(.n(31)) dut (
    .a00(a_in[0]), .a10(a_in[1]), .a20(a_in[2]), .a30(a_in[3]), .a40(a_in[4]),
    .b00(b_in[0]), .b01(b_in[1]), .b02(b_in[2]), .b03(b_in[3]), .b04(b_in[4]),
    .c00(c_in[0]), .c01(c_in[1]), .c02(c_in[2]), .c10(c_in[3]), .c20(c_in[4]),
    .a05(a_out[0]), .a15(a_out[1]), .a25(a_out[2]), .a35(a_out[3]), .a45(a_out[4]),
    .b50(b_out[0]), .b51(b_out[1]), .b52(b_out[2]), .b53(b_out[3]), .b54(b_out[4]),
    .c53(c_out[0]), .c54(c_out[1]), .c55(c_out[2]), .c35(c_out[3]), .c45(c_out[4]),
    .clock(clock),
    .reset_n(reset_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] out_val(input int p);
    if (p < 5) return a_out[p];
    else if (p < 10) return b_out[p-5];
    else return c_out[p-10];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got 0x%08h, expected 0x%08h", name, edge_cnt, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int p = 0; p < 15; p++) check($sformatf("%s_%s", tag, names[p]), out_val(p), 32'd0);
  endtask

  task automatic push(input int cyc, input int port, input logic [31:0] exp);
    exp_t e;
    e.cyc  = cyc;
    e.port = port;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic zero_inputs();
    for (int i = 0; i < 5; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
      c_in[i] = '0;
    end
  endtask

  // Monitor: compare every expectation due at this edge.
  initial begin
    exp_t e;
    edge_cnt = 0;
    forever begin
      @(posedge clock);
      edge_cnt++;
      #1;
      while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
        e = sb.pop_front();
        if (e.cyc < edge_cnt) begin
          checks++;
          errors++;
          $display("FAIL %s missed: due edge %0d, now %0d", names[e.port], e.cyc, edge_cnt);
        end else begin
          check(names[e.port], out_val(e.port), e.exp);
        end
      end
    end
  end

  // Feed ma x mb with the skewed schedule; expected results come from mc.
  // With rst_mid set, reset is pulsed after edge T0+2 and zeros are expected afterwards.
  task automatic matmul(input bit rst_mid);
    int t0;
    int rel;
    @(negedge clock);
    t0 = edge_cnt + 1;
    if (!rst_mid) begin
      push(t0+4, A05, ma[0]);
      push(t0+4, B50, mb[0]);
      push(t0+4, C55, mc[0]);
      push(t0+4, C45, mc[1]);
      push(t0+4, C35, mc[2]);
      push(t0+4, C54, mc[3]);
      push(t0+4, C53, mc[6]);
      push(t0+5, C55, mc[4]);
      push(t0+5, C45, mc[5]);
      push(t0+5, C54, mc[7]);
      push(t0+6, C55, mc[8]);
    end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clock);
      zero_inputs();
      for (int m = 0; m < 3; m++) begin
        a_in[k+m] = ma[k*3+m];
        b_in[k+m] = mb[m*3+k];
      end
    end
    @(negedge clock);
    zero_inputs();
    if (rst_mid) begin
      reset_n = 1'b0;
      #1;
      check_all_zero("mid_rst");
      @(negedge clock);
      reset_n = 1'b1;
      rel = edge_cnt;
      for (int t = 1; t <= 6; t++) begin
        push(rel+t, C53, 32'd0);
        push(rel+t, C54, 32'd0);
        push(rel+t, C55, 32'd0);
        push(rel+t, C35, 32'd0);
        push(rel+t, C45, 32'd0);
      end
    end
  endtask

  initial begin
    int t0;
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    zero_inputs();

    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // A x B with known product
    ma = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    mb = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    mc = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    matmul(1'b0);
    repeat (8) @(negedge clock);

    // A x I = A
    mb = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    mc = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    matmul(1'b0);
    repeat (8) @(negedge clock);

    // Product wraps modulo 2^32
    @(negedge clock);
    t0 = edge_cnt + 1;
    a_in[0] = 32'hFFFF_FFFF;
    b_in[0] = 32'd2;
    push(t0+4, A05, 32'hFFFF_FFFF);
    push(t0+4, C55, 32'hFFFF_FFFE);
    push(t0+5, C55, 32'd0);
    @(negedge clock);
    zero_inputs();
    repeat (8) @(negedge clock);

    // Partial sums pass through their diagonals
    @(negedge clock);
    t0 = edge_cnt + 1;
    c_in[0] = 32'd100;
    c_in[4] = 32'd7;
    push(t0+2, C53, 32'd7);
    push(t0+3, C53, 32'd0);
    push(t0+4, C55, 32'd100);
    push(t0+5, C55, 32'd0);
    @(negedge clock);
    zero_inputs();
    repeat (8) @(negedge clock);

    // Row and column pass-through latency
    @(negedge clock);
    t0 = edge_cnt + 1;
    a_in[1] = 32'h1234_5678;
    b_in[3] = 32'h0000_CAFE;
    push(t0+4, A15, 32'h1234_5678);
    push(t0+4, B53, 32'h0000_CAFE);
    push(t0+5, A15, 32'd0);
    push(t0+5, B53, 32'd0);
    @(negedge clock);
    zero_inputs();
    repeat (8) @(negedge clock);

    // Reset in the middle of a multiply
    ma = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    mb = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    matmul(1'b1);
    repeat (8) @(negedge clock);

    // Reset clears visible non-zero outputs without a clock edge
    @(negedge clock);
    t0 = edge_cnt + 1;
    a_in[1] = 32'h1234_5678;
    b_in[3] = 32'h0000_CAFE;
    @(negedge clock);
    zero_inputs();
    while (edge_cnt < t0 + 4) @(negedge clock);
    check("pre_rst_a15", a_out[1], 32'h1234_5678);
    reset_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sys_arr.md
SYS_ARR -- requirements
Module: sys_arr

Interface
REQ-001 Parameter: n, default 31, MSB index of every data port (data width n+1 = 32 bits).
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset_n  in  1  reset, active-low, asynchronous.
REQ-004 a00,a10,a20,a30,a40  in  n+1  row inputs; row i enters at the left of grid row i.
REQ-005 b00,b01,b02,b03,b04  in  n+1  column inputs; column j enters at the top of grid column j.
REQ-006 c00,c01,c02,c10,c20  in  n+1  partial-sum inputs, one per computing diagonal.
REQ-007 a05,a15,a25,a35,a45  out  n+1  row i data leaving the right edge of the grid.
REQ-008 b50,b51,b52,b53,b54  out  n+1  column j data leaving the bottom edge of the grid.
REQ-009 c53,c54,c55,c35,c45  out  n+1  accumulated diagonal results.
REQ-010 Port declaration order shall be a00..a40, b00..b04, c00,c01,c02,c10,c20, a05..a45, b50..b54, c53,c54,c55,c35,c45, clock, reset_n.

Function
REQ-011 Grid shall be 5x5 processing elements PE(i,j), i = row 0..4, j = column 0..4.
REQ-012 Each PE shall register three values per rising clock edge: a_out <= a_in, b_out <= b_in, c_out <= c_in + a_in*b_in.
REQ-013 a shall flow right: PE(i,j).a_in = PE(i,j-1).a_out; PE(i,0).a_in = ai0; ai5 = PE(i,4).a_out.
REQ-014 b shall flow down: PE(i,j).b_in = PE(i-1,j).b_out; PE(0,j).b_in = b0j; b5j = PE(4,j).b_out.
REQ-015 c shall flow diagonally: PE(i,j).c_in = PE(i-1,j-1).c_out.
REQ-016 Diagonal heads and tails: c00->PE(0,0)...PE(4,4)->c55; c01->PE(0,1)...PE(3,4)->c45; c02->PE(0,2)...PE(2,4)->c35; c10->PE(1,0)...PE(4,3)->c54; c20->PE(2,0)...PE(4,2)->c53.
REQ-017 c_in of PE(0,3), PE(0,4), PE(3,0) and PE(4,0) shall be tied to 0; those diagonals' results are not output.
REQ-018 Arithmetic: product and sum shall be truncated to the low n+1 bits (modulo 2^32); the result is identical for signed and unsigned operands; no saturation, no overflow flag.
REQ-019 Latency: ai5 and b5j shall equal the input presented 5 edges earlier.
REQ-020 A value entering diagonal k shall reach its output after L edges, with L = 5 (c00 diagonal), 4 (c01, c10), 3 (c02, c20).
REQ-021 Usage contract for C = A x B (3x3, row-major).
  - Edge T0: a00,a10,a20 = A00,A01,A02; b00,b01,b02 = B00,B10,B20.
  - T0+1: a10,a20,a30 = A10,A11,A12; b01,b02,b03 = B01,B11,B21.
  - T0+2: a20,a30,a40 = A20,A21,A22; b02,b03,b04 = B02,B12,B22.
  - All other a/b inputs and all c inputs 0.
  - After edge T0+4: c55=C00, c45=C01, c35=C02, c54=C10, c53=C20.
  - After edge T0+5: c55=C11, c45=C12, c54=C21.
  - After edge T0+6: c55=C22.
REQ-022 Inputs are sampled every edge; there is no handshake, stall or valid signal, and a new matrix pair may start any cycle after the previous one's last input cycle.

Reset
REQ-023 reset_n low shall asynchronously clear every PE register, so all outputs are 0 while it is low.
REQ-024 Reset asserted mid-operation shall discard all in-flight data; the first edge after release shall sample inputs normally.

Verification
REQ-025 A=[[1,2,3],[4,5,6],[7,8,9]], B=[[9,8,7],[6,5,4],[3,2,1]] per REQ-021 -> the following values:
  - After edge T0+4: c55=30, c45=24, c35=18, c54=84, c53=138.
  - After edge T0+5: c55=69, c45=54, c54=114.
  - After edge T0+6: c55=90.
REQ-026 B = identity, same A -> C equals A at the times given in REQ-021.
REQ-027 a00=0xFFFFFFFF, b00=2 for one cycle, all else 0 -> c55=0xFFFFFFFE after 5 edges for one cycle, then 0.
REQ-028 c00=100, c20=7, all a/b 0, one cycle -> c55=100 after 5 edges and c53=7 after 3 edges.
REQ-029 a10=0x12345678 and b03=0xCAFE for one cycle -> a15=0x12345678 and b53=0xCAFE after 5 edges, each for one cycle.
REQ-030 Drive reset_n low at T0+2 of scenario REQ-025 -> all outputs 0 immediately, with no edge needed; after release and all-zero inputs, outputs stay 0.
